// File: rtl/fft_frame_sequencer_pkg.sv
// ============================================================================
// Module : fft_frame_sequencer_pkg
// Brief  : Shared constants, FSM state encoding and log2 helper.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fft_frame_sequencer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } fsm_state_e;

  // Ceiling log2; usable in parameter expressions.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fft_frame_sequencer_fifo.sv
// ============================================================================
// Module : fft_frame_sequencer_fifo
// Brief  : Synchronous FIFO with registered read port and occupancy count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_frame_sequencer_fifo
  import fft_frame_sequencer_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear_i,
  input  logic                    push_i,
  input  logic [DW-1:0]           push_data_i,
  input  logic                    pop_i,
  output logic [DW-1:0]           pop_data_o,
  output logic [clog2(DEPTH):0]   count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic [DW-1:0] rd_data_q;
  logic          push_ok_w, pop_ok_w;

  assign full_o     = (count_q == C_DEPTH);
  assign empty_o    = (count_q == '0);
  assign push_ok_w  = push_i & ~full_o;
  assign pop_ok_w   = pop_i & ~empty_o;
  assign count_o    = count_q;
  assign pop_data_o = rd_data_q;

  always_ff @(posedge clock) begin
    if (push_ok_w) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      if (push_ok_w) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok_w) begin
        rd_ptr_q  <= rd_ptr_q + AW'(1);
        rd_data_q <= mem_q[rd_ptr_q];
      end
      case ({push_ok_w, pop_ok_w})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fft_frame_sequencer.sv
// ============================================================================
// Module : fft_frame_sequencer
// Brief  : Frames a stalling sample stream into N-cycle FFT enable bursts and
//          tags FFT output samples with sop/eop/frame index.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_frame_sequencer
  import fft_frame_sequencer_pkg::*;
#(
  parameter int N          = 64,
  parameter int WIDTH      = 16,
  parameter int DEPTH      = N,
  parameter int FW         = 8,
  parameter int LAT_FRAMES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data_r,
  input  logic [WIDTH-1:0] s_data_i,
  input  logic             flush,
  output logic             fft_idata_en,
  output logic [WIDTH-1:0] fft_idata_r,
  output logic [WIDTH-1:0] fft_idata_i,
  input  logic             fft_odata_en,
  input  logic [WIDTH-1:0] fft_odata_r,
  input  logic [WIDTH-1:0] fft_odata_i,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data_r,
  output logic [WIDTH-1:0] m_data_i,
  output logic             m_sop,
  output logic             m_eop,
  output logic [FW-1:0]    m_frame,
  output logic             busy,
  output logic             err_gap
);

  localparam int LN  = clog2(N);
  localparam int CW  = clog2(DEPTH) + 1;
  localparam int IFW = clog2(DEPTH / N + LAT_FRAMES + 1);
  localparam logic [LN-1:0] C_LAST = LN'(N - 1);
  localparam logic [CW-1:0] C_N    = CW'(N);
  localparam logic [CW-1:0] C_NP1  = CW'(N + 1);

  fsm_state_e         state_q, state_d;
  logic [LN-1:0]      in_count_q, in_count_d;
  logic               en_q;
  logic               push_w, pop_w, clear_w, start_w, dec_w;
  logic [CW-1:0]      fifo_count_w;
  logic               fifo_full_w, fifo_empty_w;
  logic [2*WIDTH-1:0] fifo_rd_w;

  logic [LN-1:0]      out_count_q;
  logic [FW-1:0]      frame_cnt_q, m_frame_q;
  logic               m_valid_q, m_sop_q, m_eop_q, err_gap_q;
  logic [WIDTH-1:0]   m_data_r_q, m_data_i_q;
  logic [IFW-1:0]     in_flight_q;

  assign s_ready = ~fifo_full_w;
  assign push_w  = s_valid & s_ready;

  fft_frame_sequencer_fifo #(
    .DW    (2*WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (clear_w),
    .push_i      (push_w),
    .push_data_i ({s_data_r, s_data_i}),
    .pop_i       (pop_w),
    .pop_data_o  (fifo_rd_w),
    .count_o     (fifo_count_w),
    .full_o      (fifo_full_w),
    .empty_o     (fifo_empty_w)
  );

  always_comb begin
    state_d    = state_q;
    in_count_d = in_count_q;
    pop_w      = 1'b0;
    clear_w    = 1'b0;
    start_w    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fifo_count_w >= C_N) begin
          state_d    = ST_BURST;
          in_count_d = '0;
          start_w    = 1'b1;
        end else if (flush) begin
          clear_w = 1'b1;
        end
      end
      ST_BURST: begin
        pop_w      = ~fifo_empty_w;
        in_count_d = in_count_q + LN'(1);
        if (in_count_q == C_LAST) begin
          // Occupancy after this pop (plus any concurrent push) decides chaining.
          if (fifo_count_w + CW'(push_w) >= C_NP1) start_w = 1'b1;
          else                                     state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      in_count_q <= '0;
      en_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_count_q <= in_count_d;
      en_q       <= pop_w;
    end
  end

  assign fft_idata_en = en_q;
  assign fft_idata_r  = en_q ? fifo_rd_w[2*WIDTH-1:WIDTH] : '0;
  assign fft_idata_i  = en_q ? fifo_rd_w[WIDTH-1:0]       : '0;

  assign dec_w = fft_odata_en & (out_count_q == C_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      out_count_q <= '0;
      frame_cnt_q <= '0;
      m_frame_q   <= '0;
      m_valid_q   <= 1'b0;
      m_sop_q     <= 1'b0;
      m_eop_q     <= 1'b0;
      m_data_r_q  <= '0;
      m_data_i_q  <= '0;
      err_gap_q   <= 1'b0;
    end else begin
      m_valid_q <= fft_odata_en;
      if (fft_odata_en) begin
        out_count_q <= out_count_q + LN'(1);
        m_sop_q     <= (out_count_q == '0);
        m_eop_q     <= (out_count_q == C_LAST);
        m_frame_q   <= frame_cnt_q;
        m_data_r_q  <= fft_odata_r;
        m_data_i_q  <= fft_odata_i;
        if (out_count_q == C_LAST) frame_cnt_q <= frame_cnt_q + FW'(1);
      end else begin
        m_sop_q    <= 1'b0;
        m_eop_q    <= 1'b0;
        m_data_r_q <= '0;
        m_data_i_q <= '0;
        if (out_count_q != '0) err_gap_q <= 1'b1;
        out_count_q <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_flight_q <= '0;
    end else begin
      case ({start_w, dec_w})
        2'b10:   in_flight_q <= in_flight_q + IFW'(1);
        2'b01:   in_flight_q <= in_flight_q - IFW'(1);
        default: in_flight_q <= in_flight_q;
      endcase
    end
  end

  // An output frame can only complete for a frame that was actually launched.
  always_ff @(posedge clock) begin
    if (!reset && dec_w && !start_w) assert (in_flight_q != '0);
  end

  assign m_valid  = m_valid_q;
  assign m_data_r = m_data_r_q;
  assign m_data_i = m_data_i_q;
  assign m_sop    = m_sop_q;
  assign m_eop    = m_eop_q;
  assign m_frame  = m_frame_q;
  assign err_gap  = err_gap_q;
  assign busy     = (state_q == ST_BURST) | (in_flight_q != '0);

endmodule

`default_nettype wire

// File: tb/tb_fft_frame_sequencer.sv
// ============================================================================
// Module : tb_fft_frame_sequencer
// Brief  : Directed/randomized self-checking bench for fft_frame_sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fft_frame_sequencer;

  localparam int N  = 64;
  localparam int W  = 16;
  localparam int FW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, flush;
  logic          s_valid, s_ready, en, oen;
  logic [W-1:0]  s_dr, s_di, idr, idi, odr, odi, m_dr, m_di;
  logic          m_valid, m_sop, m_eop, busy, err_gap;
  logic [FW-1:0] m_frame;

  logic          s_valid2, s_ready2, en2, flush2, oen2;
  logic [W-1:0]  s_dr2, s_di2, idr2, idi2, odr2, odi2, mdr2, mdi2;
  logic          mv2, msop2, meop2, busy2, err2;
  logic [FW-1:0] mfr2;

  fft_frame_sequencer #(.N(N), .WIDTH(W), .DEPTH(2*N), .FW(FW)) dut (
    .clock(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_data_r(s_dr), .s_data_i(s_di), .flush(flush),
    .fft_idata_en(en), .fft_idata_r(idr), .fft_idata_i(idi),
    .fft_odata_en(oen), .fft_odata_r(odr), .fft_odata_i(odi),
    .m_valid(m_valid), .m_data_r(m_dr), .m_data_i(m_di), .m_sop(m_sop),
    .m_eop(m_eop), .m_frame(m_frame), .busy(busy), .err_gap(err_gap));

  fft_frame_sequencer #(.N(N), .WIDTH(W), .DEPTH(N), .FW(FW)) dut_s (
    .clock(clk), .reset(reset), .s_valid(s_valid2), .s_ready(s_ready2),
    .s_data_r(s_dr2), .s_data_i(s_di2), .flush(flush2),
    .fft_idata_en(en2), .fft_idata_r(idr2), .fft_idata_i(idi2),
    .fft_odata_en(oen2), .fft_odata_r(odr2), .fft_odata_i(odi2),
    .m_valid(mv2), .m_data_r(mdr2), .m_data_i(mdi2), .m_sop(msop2),
    .m_eop(meop2), .m_frame(mfr2), .busy(busy2), .err_gap(err2));

  int vectors = 0;
  int miscompares = 0;

  logic [31:0]   exp_q[$], obs_q[$], exp2[$], obs2[$];
  int            runs[$];
  int            run_len = 0;
  int            peak_if = 0;
  logic          mon_on = 1'b0;
  int            mcnt = 0;
  logic [FW-1:0] mfrm = '0;
  logic          mgap = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (en) begin
        obs_q.push_back({idr, idi});
        run_len++;
      end else begin
        if (run_len != 0) begin
          runs.push_back(run_len);
          run_len = 0;
        end
        chk("idata_gate", {idr, idi}, 64'd0);
      end
      if (en2) obs2.push_back({idr2, idi2});
      if (int'(dut.in_flight_q) > peak_if) peak_if = int'(dut.in_flight_q);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cycle(input logic v, output logic acc);
    logic [W-1:0] r, i;
    r = W'($urandom);
    i = W'($urandom);
    s_valid = v; s_dr = r; s_di = i;
    @(negedge clk);
    acc = v & s_ready;
    tick();
    if (acc) exp_q.push_back({r, i});
    s_valid = 1'b0;
  endtask

  task automatic push_n(input int n, input int maxgap);
    int   got;
    logic acc;
    got = 0;
    for (int t = 0; t < 4*n + 50 && got < n; t++) begin
      repeat ($urandom_range(0, maxgap)) push_cycle(1'b0, acc);
      push_cycle(1'b1, acc);
      if (acc) got++;
    end
    chk("push_count", got, n);
  endtask

  task automatic wait_run(input string tag, input int exp_len, input int bound);
    int len;
    for (int c = 0; c < bound && runs.size() == 0; c++) tick();
    len = (runs.size() != 0) ? runs.pop_front() : -1;
    chk(tag, len, exp_len);
  endtask

  task automatic cmp_frame(input string tag, input int n);
    logic [31:0] o, e;
    for (int k = 0; k < n; k++) begin
      o = (obs_q.size() != 0) ? obs_q.pop_front() : 32'hxxxx_xxxx;
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
      chk(tag, o, e);
    end
  endtask

  task automatic out_cycle(input logic e);
    logic [W-1:0] r, i;
    r = W'($urandom);
    i = W'($urandom);
    oen = e; odr = r; odi = i;
    tick();
    chk("m_valid", m_valid, e);
    chk("m_sop", m_sop, e && (mcnt == 0));
    chk("m_eop", m_eop, e && (mcnt == N-1));
    if (e) begin
      chk("m_data", {m_dr, m_di}, {r, i});
      chk("m_frame", m_frame, mfrm);
      if (mcnt == N-1) begin mcnt = 0; mfrm = mfrm + 1'b1; end
      else mcnt++;
    end else begin
      if (mcnt != 0) mgap = 1'b1;
      mcnt = 0;
    end
    chk("err_gap", err_gap, mgap);
    oen = 1'b0;
  endtask

  initial begin
    int   stalls, acc2;
    logic rdy;
    logic [31:0] o, e;
    reset = 1'b1; flush = 1'b0; s_valid = 1'b0; s_dr = '0; s_di = '0;
    oen = 1'b0; odr = '0; odi = '0;
    s_valid2 = 1'b0; s_dr2 = '0; s_di2 = '0; flush2 = 1'b0;
    oen2 = 1'b0; odr2 = '0; odi2 = '0;
    repeat (3) tick();
    reset = 1'b0;
    mon_on = 1'b1;

    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_en", en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_outs", {m_valid, m_sop, m_eop, err_gap, m_frame, m_dr, m_di}, 64'd0);

    // Full FIFO on the DEPTH==N instance: exactly two stalled cycles before pops start.
    stalls = 0; acc2 = 0;
    for (int t = 0; t < 300 && acc2 < 70; t++) begin
      s_valid2 = 1'b1; s_dr2 = W'($urandom); s_di2 = W'($urandom);
      @(negedge clk);
      rdy = s_ready2;
      if (!rdy) stalls++;
      tick();
      if (rdy) begin exp2.push_back({s_dr2, s_di2}); acc2++; end
    end
    s_valid2 = 1'b0;
    for (int c = 0; c < 200 && obs2.size() < N; c++) tick();
    chk("full_stalls", stalls, 2);
    chk("full_burst_len", obs2.size(), N);
    for (int k = 0; k < N; k++) begin
      o = (obs2.size() != 0) ? obs2.pop_front() : 32'hxxxx_xxxx;
      e = (exp2.size() != 0) ? exp2.pop_front() : 32'hxxxx_xxxx;
      chk("full_data", o, e);
    end
    repeat (3) tick();
    chk("full_residual", dut_s.u_fifo.count_o, exp2.size());
    chk("small_outs_idle", {mv2, msop2, meop2, err2, mfr2, mdr2, mdi2}, 64'd0);

    // One frame with random gaps; nothing launched before the last sample.
    push_n(N-1, 3);
    repeat (5) tick();
    chk("no_early_en", obs_q.size(), 0);
    push_n(1, 3);
    wait_run("t1_run", N, 200);
    cmp_frame("t1_data", N);
    chk("t1_busy", busy, 1'b1);
    for (int k = 0; k < N; k++) out_cycle(1'b1);
    out_cycle(1'b0);
    chk("t1_drained", busy, 1'b0);

    // Two frames back-to-back form one contiguous 2N enable run.
    peak_if = 0;
    push_n(2*N, 0);
    wait_run("t2_run", 2*N, 400);
    cmp_frame("t2_data", 2*N);
    chk("t2_peak_inflight", peak_if, 2);
    for (int k = 0; k < 2*N; k++) out_cycle(1'b1);
    out_cycle(1'b0);
    chk("t2_drained", busy, 1'b0);

    // Output-side gap: drop at sample 20, then a fresh partial frame.
    for (int k = 0; k < 20; k++) out_cycle(1'b1);
    out_cycle(1'b0);
    for (int k = 0; k < 5; k++) out_cycle(1'b1);
    out_cycle(1'b0);

    // Flush a partial frame, then a clean frame.
    push_n(10, 2);
    repeat (2) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    exp_q.delete();
    tick();
    chk("flush_empty", dut.u_fifo.empty_o, 1'b1);
    push_n(N, 1);
    wait_run("t4_run", N, 200);
    cmp_frame("t4_data", N);

    // Reset in the middle of a burst.
    push_n(N, 0);
    for (int c = 0; c < 200 && run_len < 30; c++) @(negedge clk);
    chk("t6_reached", run_len, 30);
    reset = 1'b1;
    tick();
    chk("t6_en", en, 1'b0);
    chk("t6_busy", busy, 1'b0);
    chk("t6_s_ready", s_ready, 1'b1);
    chk("t6_empty", dut.u_fifo.empty_o, 1'b1);
    chk("t6_err_clr", err_gap, 1'b0);
    chk("t6_idata", {idr, idi}, 64'd0);
    reset = 1'b0;
    repeat (3) tick();
    chk("t6_no_restart", en, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
